// File: rtl/ide_pio_pkg.sv
// Shared types and PIO timing tables for the IDE bus-cycle sequencer.
package ide_pio_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    ACK    = 3'd4,
    REC    = 3'd5,
    ROMW   = 3'd6
  } state_t;

  typedef struct packed {
    logic [2:0] t1;
    logic [2:0] t2;
    logic [2:0] rec;
  } timing_t;

  // Indexed by PIO mode; values are CLK cycles.
  localparam logic [2:0] T1_TAB  [4] = '{3'd2, 3'd1, 3'd1, 3'd1};
  localparam logic [2:0] T2_TAB  [4] = '{3'd5, 3'd4, 3'd3, 3'd2};
  localparam logic [2:0] REC_TAB [4] = '{3'd4, 3'd3, 3'd2, 3'd1};

  function automatic timing_t pio_timing(input logic [1:0] mode);
    timing_t t;
    t.t1  = T1_TAB[mode];
    t.t2  = T2_TAB[mode];
    t.rec = REC_TAB[mode];
    return t;
  endfunction

endpackage

// File: rtl/ide_pio_timer.sv
// 3-bit loadable down-counter shared by all timed sequencer states.
module ide_pio_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [2:0] value,
  output logic       zero
);

  logic [2:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 3'd1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/ide_pio_sequencer.sv
// Sequences IDE register and boot-ROM bus cycles for both ATA ports with
// per-port PIO timing; every output is a register.
module ide_pio_sequencer
  import ide_pio_pkg::*;
#(
  parameter logic [1:0]  DEFAULT_MODE = 2'd0,
  parameter int unsigned ROM_WAIT     = 1,
  parameter int unsigned REC_EXTRA    = 0
) (
  input  logic       CLK,
  input  logic       RESET_n,
  input  logic       AS_n,
  input  logic       UDS_n,
  input  logic       LDS_n,
  input  logic       RW,
  input  logic       ide_access,
  input  logic       rom_sel,
  input  logic       port_sel,
  input  logic       cs_sel,
  input  logic       cfg_we,
  input  logic       cfg_port,
  input  logic [1:0] cfg_mode,
  output logic       IOR_n,
  output logic       IOW_n,
  output logic [1:0] IDE1_CS_n,
  output logic [1:0] IDE2_CS_n,
  output logic       DTACK,
  output logic       busy
);

  localparam logic [2:0] ROM_WAIT_M1 = 3'(ROM_WAIT - 1);

  state_t     state_q, state_d;
  logic [1:0] mode_q [2];
  logic       port_q, cs_q, rd_q, abort_q;
  logic       port_d, cs_d, rd_d, abort_d;
  logic [2:0] t2_q, rec_q, t2_d, rec_d;
  logic       start, take;
  timing_t    tim_sel;
  logic       tmr_load, tmr_zero;
  logic [2:0] tmr_value;
  logic       cs_act, strobe, dtack_d;
  logic [1:0] cs_lo;

  ide_pio_timer u_timer (
    .clk   (CLK),
    .rst_n (RESET_n),
    .load  (tmr_load),
    .value (tmr_value),
    .zero  (tmr_zero)
  );

  always_comb begin
    start   = ide_access && !AS_n && (!UDS_n || !LDS_n);
    take    = (state_q == IDLE) && start;
    tim_sel = pio_timing(mode_q[port_sel]);
    // Cycle attributes are captured on the start edge so later cfg writes
    // cannot disturb a cycle already in flight.
    port_d  = take ? port_sel : port_q;
    cs_d    = take ? cs_sel : cs_q;
    rd_d    = take ? RW : rd_q;
    t2_d    = take ? tim_sel.t2 : t2_q;
    rec_d   = take ? (rom_sel ? 3'd0 : tim_sel.rec + 3'(REC_EXTRA)) : rec_q;
    abort_d = take ? 1'b0 : abort_q;

    state_d   = state_q;
    tmr_load  = 1'b0;
    tmr_value = '0;
    cs_act    = 1'b0;
    strobe    = 1'b0;
    dtack_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (take) begin
          if (!rom_sel) begin
            state_d   = SETUP;
            cs_act    = 1'b1;
            tmr_load  = 1'b1;
            tmr_value = tim_sel.t1 - 3'd1;
          end else if (ROM_WAIT == 0) begin
            state_d = ACK;
            dtack_d = 1'b1;
          end else begin
            state_d   = ROMW;
            tmr_load  = 1'b1;
            tmr_value = ROM_WAIT_M1;
          end
        end
      end
      ROMW: begin
        if (AS_n) begin
          state_d   = (rec_q == '0) ? IDLE : REC;
          tmr_load  = (rec_q != '0);
          tmr_value = rec_q - 3'd1;
        end else if (tmr_zero) begin
          state_d = ACK;
          dtack_d = 1'b1;
        end
      end
      SETUP: begin
        if (AS_n) begin
          state_d   = (rec_q == '0) ? IDLE : REC;
          tmr_load  = (rec_q != '0);
          tmr_value = rec_q - 3'd1;
        end else begin
          cs_act = 1'b1;
          if (tmr_zero) begin
            state_d   = STROBE;
            strobe    = 1'b1;
            tmr_load  = 1'b1;
            tmr_value = t2_q - 3'd1;
          end
        end
      end
      STROBE: begin
        cs_act = 1'b1;
        if (AS_n) begin
          state_d = HOLD;
          abort_d = 1'b1;
        end else if (tmr_zero) begin
          state_d = HOLD;
        end else begin
          strobe = 1'b1;
        end
      end
      HOLD: begin
        if (abort_q) begin
          state_d   = (rec_q == '0) ? IDLE : REC;
          tmr_load  = (rec_q != '0);
          tmr_value = rec_q - 3'd1;
        end else begin
          state_d = ACK;
          dtack_d = 1'b1;
        end
      end
      ACK: begin
        if (AS_n) begin
          state_d   = (rec_q == '0) ? IDLE : REC;
          tmr_load  = (rec_q != '0);
          tmr_value = rec_q - 3'd1;
        end else begin
          dtack_d = 1'b1;
        end
      end
      REC: begin
        if (tmr_zero) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    cs_lo = cs_d ? 2'b01 : 2'b10;
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q   <= IDLE;
      mode_q[0] <= DEFAULT_MODE;
      mode_q[1] <= DEFAULT_MODE;
      port_q    <= 1'b0;
      cs_q      <= 1'b0;
      rd_q      <= 1'b1;
      abort_q   <= 1'b0;
      t2_q      <= '0;
      rec_q     <= '0;
      IOR_n     <= 1'b1;
      IOW_n     <= 1'b1;
      IDE1_CS_n <= '1;
      IDE2_CS_n <= '1;
      DTACK     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cfg_we) mode_q[cfg_port] <= cfg_mode;
      port_q    <= port_d;
      cs_q      <= cs_d;
      rd_q      <= rd_d;
      abort_q   <= abort_d;
      t2_q      <= t2_d;
      rec_q     <= rec_d;
      IOR_n     <= !(strobe && rd_d);
      IOW_n     <= !(strobe && !rd_d);
      IDE1_CS_n <= (cs_act && !port_d) ? cs_lo : 2'b11;
      IDE2_CS_n <= (cs_act && port_d) ? cs_lo : 2'b11;
      DTACK     <= dtack_d;
      busy      <= (state_d != IDLE);
    end
  end

endmodule
